// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and sticky error flags.
// Latency: registered read loads o_dout one cycle after an accepted deq; show-ahead presents the head word combinationally.
// Backpressure: enq is dropped when full unless a pop is accepted on the same edge; deq is ignored when empty.
module fifo_param #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int SHOW_AHEAD = 0,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_enq,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_deq,
    input  logic                     i_clr_err,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_almost_full,
    output logic                     o_almost_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   L_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   L_AF      = (AW+1)'(AF_THRESH);
    localparam logic [AW:0]   L_AE      = (AW+1)'(AE_THRESH);
    localparam logic [AW:0]   L_CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] L_PTR_ONE = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic w_full;
    logic w_empty;
    logic w_deq_ok;
    logic w_enq_ok;
    logic w_ovf_evt;
    logic w_unf_evt;

    // Flags come straight off the count register, so they track the last accepted operation with no extra delay.
    assign w_full    = (r_count == L_DEPTH);
    assign w_empty   = (r_count == '0);

    // A pop frees a slot on the same edge, so a full FIFO can still take a push alongside an accepted pop.
    assign w_deq_ok  = i_deq & ~w_empty;
    assign w_enq_ok  = i_enq & (~w_full | w_deq_ok);
    assign w_ovf_evt = i_enq & w_full & ~w_deq_ok;
    assign w_unf_evt = i_deq & w_empty;

    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_almost_full  = (r_count >= L_AF);
    assign o_almost_empty = (r_count <= L_AE);
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

    // Storage array is not reset; writes are suppressed during reset so stale contents are simply abandoned.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_enq_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq_ok) begin
                r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
            end
            if (w_deq_ok) begin
                r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
            end
            case ({w_enq_ok, w_deq_ok})
                2'b10:   r_count <= r_count + L_CNT_ONE;
                2'b01:   r_count <= r_count - L_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new error event on the same edge as clr_err takes priority over the clear.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_clr_err) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
            if (w_unf_evt) begin
                r_underflow <= 1'b1;
            end
        end
    end

    generate
        if (SHOW_AHEAD != 0) begin : g_show_ahead
            // Head entry is visible as soon as it is written; value is meaningless while empty.
            assign o_dout = r_mem[r_rd_ptr];
        end else begin : g_registered
            logic [WIDTH-1:0] r_dout;

            // Registered read: capture the outgoing head word on each accepted pop and hold it otherwise.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_dout <= '0;
                end else if (w_deq_ok) begin
                    r_dout <= r_mem[r_rd_ptr];
                end
            end

            assign o_dout = r_dout;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: registered-read and show-ahead instances driven in lockstep.
// Latency: reference queue model is updated at each posedge and compared 1 time unit later.
// Backpressure: model applies the accept/drop/ignore rules directly on a queue.
module tb_fifo_param;

    localparam int D = 8;

    logic       clk;
    logic       rst;
    logic       enq;
    logic       deq;
    logic       clr;
    logic [7:0] din;

    logic [7:0] dout0, dout1;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [3:0] cnt0, cnt1;

    fifo_param #(.WIDTH(8), .DEPTH(D), .SHOW_AHEAD(0), .AF_THRESH(6), .AE_THRESH(1)) u_reg (
        .i_clk(clk), .i_reset(rst), .i_enq(enq), .i_din(din), .i_deq(deq), .i_clr_err(clr),
        .o_dout(dout0), .o_full(full0), .o_empty(empty0), .o_almost_full(af0),
        .o_almost_empty(ae0), .o_count(cnt0), .o_overflow(ovf0), .o_underflow(unf0)
    );

    fifo_param #(.WIDTH(8), .DEPTH(D), .SHOW_AHEAD(1), .AF_THRESH(6), .AE_THRESH(1)) u_fwft (
        .i_clk(clk), .i_reset(rst), .i_enq(enq), .i_din(din), .i_deq(deq), .i_clr_err(clr),
        .o_dout(dout1), .o_full(full1), .o_empty(empty1), .o_almost_full(af1),
        .o_almost_empty(ae1), .o_count(cnt1), .o_overflow(ovf1), .o_underflow(unf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int max_cnt = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_dout;
    logic       m_ovf;
    logic       m_unf;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input logic e, input logic d, input logic [7:0] v,
                                input logic c, input logic r);
        int  sz;
        bit  pop_ok, push_ok;
        if (r) begin
            q.delete();
            m_dout = 8'h00;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            sz      = q.size();
            pop_ok  = d && (sz > 0);
            push_ok = e && ((sz < D) || pop_ok);
            if (c) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (e && (sz == D) && !pop_ok) m_ovf = 1'b1;
            if (d && (sz == 0))            m_unf = 1'b1;
            if (pop_ok)  m_dout = q.pop_front();
            if (push_ok) q.push_back(v);
        end
    endtask

    task automatic compare_all();
        int sz;
        sz = q.size();
        if (sz > max_cnt) max_cnt = sz;
        check_eq("count",        32'(cnt0),  32'(sz));
        check_eq("full",         32'(full0), 32'(sz == D));
        check_eq("empty",        32'(empty0), 32'(sz == 0));
        check_eq("almost_full",  32'(af0),   32'(sz >= 6));
        check_eq("almost_empty", 32'(ae0),   32'(sz <= 1));
        check_eq("overflow",     32'(ovf0),  32'(m_ovf));
        check_eq("underflow",    32'(unf0),  32'(m_unf));
        check_eq("dout_reg",     32'(dout0), 32'(m_dout));
        check_eq("count_sa",     32'(cnt1),  32'(sz));
        check_eq("flags_sa",     {26'b0, full1, empty1, af1, ae1, ovf1, unf1},
                                 {26'b0, 1'(sz == D), 1'(sz == 0), 1'(sz >= 6), 1'(sz <= 1), m_ovf, m_unf});
        if (sz > 0) begin
            check_eq("dout_sa", 32'(dout1), 32'(q[0]));
        end
    endtask

    task automatic step(input logic e, input logic d, input logic [7:0] v,
                        input logic c, input logic r);
        enq = e;
        deq = d;
        din = v;
        clr = c;
        rst = r;
        @(posedge clk);
        model_update(e, d, v, c, r);
        #1;
        compare_all();
    endtask

    initial begin
        enq = 1'b0; deq = 1'b0; clr = 1'b0; din = 8'h00; rst = 1'b1;
        q.delete(); m_dout = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
        @(negedge clk);

        // Reset state
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 0);

        // Basic enqueue then drain, registered read latency
        step(1, 0, 8'h11, 0, 0);
        step(1, 0, 8'h22, 0, 0);
        step(1, 0, 8'h33, 0, 0);
        step(1, 0, 8'h44, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);

        // Fill, overflow drop, drain, clear
        for (int i = 1; i <= 8; i++) step(1, 0, 8'(i), 0, 0);
        step(1, 0, 8'hFF, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 1, 0);

        // Full pass-through: push and pop on the same edge
        for (int i = 1; i <= 8; i++) step(1, 0, 8'(i), 0, 0);
        step(1, 1, 8'hA5, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0, 0);

        // Underflow, and enq+deq on empty
        step(0, 1, 8'h00, 0, 0);
        step(1, 1, 8'h3C, 0, 0);
        step(0, 1, 8'h00, 0, 0);
        // Clear coinciding with a new underflow: set wins
        step(0, 1, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);

        // Streaming across several pointer wraps
        step(1, 0, 8'h00, 0, 0);
        for (int i = 1; i < 20; i++) step(1, 1, 8'(i), 0, 0);
        step(0, 1, 8'h00, 0, 0);
        check_eq("stream_peak", 32'(max_cnt <= D), 32'(1));

        // Show-ahead visibility and reset mid-stream
        step(1, 0, 8'h5A, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        step(1, 0, 8'h6B, 0, 0);
        step(1, 1, 8'h99, 1, 1);
        step(1, 0, 8'h77, 0, 0);
        step(0, 1, 8'h00, 0, 0);

        // Randomized traffic with drifting fill bias, occasional clears and resets
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = ((i / 200) % 2 == 0) ? 70 : 30;
            step(1'($urandom_range(99) < bias),
                 1'($urandom_range(99) < (100 - bias)),
                 8'($urandom),
                 1'($urandom_range(15) == 0),
                 1'($urandom_range(299) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous single-clock FIFO. It is the successor to the team's fixed-size 8-bit FIFO and keeps the same enq/deq/full/empty interface. It adds configurable depth, a selectable read mode (registered or show-ahead), an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It sits between byte producers and consumers in the datapath (e.g. UART/sensor byte streams).

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2; AW = $clog2(DEPTH)
SHOW_AHEAD, 0, 0 = registered read (dout loads on accepted deq); 1 = first-word-fall-through (dout shows head entry)
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  in  1  rising-edge clock; single clock domain
reset  in  1  synchronous, active-high; sampled on rising edge of clk
enq  in  1  write request; din is captured when accepted
din  in  WIDTH  write data
deq  in  1  read/pop request
clr_err  in  1  synchronous clear of overflow/underflow
dout  out  WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  AW+1  current occupancy, 0..DEPTH
overflow  out  1  sticky; enq was dropped
underflow  out  1  sticky; deq was ignored

Behaviour:
- Storage: DEPTH x WIDTH array, not reset. wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH. count is a register.
- Reset (reset=1 at a posedge): wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0, dout=0 (SHOW_AHEAD=0). Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=0.
- While reset is high, enq/deq/clr_err are ignored. A reset mid-stream discards all contents; the first post-reset enq writes slot 0.
- Acceptance, evaluated each posedge:
  - deq_ok = deq & ~empty
  - enq_ok = enq & (~full | deq_ok). When full, a simultaneous accepted pop allows the push (pass-through).
- enq_ok: mem[wr_ptr] <= din; wr_ptr++.
- deq_ok: rd_ptr++.
- count update: +1 for enq_ok only, -1 for deq_ok only, unchanged when both or neither.
- Empty with both enq and deq asserted: the write is accepted, the deq is ignored and counts as underflow, and count becomes 1.
- Flags (full, empty, almost_*) are decoded from the count register. They reflect the operation accepted at a posedge immediately after that posedge; there is no extra latency.
- SHOW_AHEAD=0:
  - On deq_ok, dout <= mem[rd_ptr] (the old head). dout is valid after the accepting posedge and holds until the next deq_ok.
  - Read latency is 1 cycle from deq sample.
- SHOW_AHEAD=1:
  - dout = mem[rd_ptr] combinationally whenever empty=0; deq pops the displayed word.
  - An entry written at posedge N appears on dout after posedge N when the FIFO was empty.
  - dout is unspecified when empty=1.
- Error flags:
  - overflow <= 1 when enq & full & ~deq_ok.
  - underflow <= 1 when deq & empty.
  - clr_err=1 clears both. If clr_err coincides with a new error event, the set wins.
  - Dropped or ignored operations change no pointer, count or data.
- Wrap-around: the pointers wrap seamlessly and data order is preserved across any number of wraps.

Test Plan:
1. DEPTH=8, SHOW_AHEAD=0: reset, enq 11,22,33,44 on consecutive cycles -> count=4, empty=0. Then 4 deqs -> dout=11,22,33,44, each valid one cycle after its deq; finally empty=1, count=0.
2. Fill to 8 with 01..08 -> full=1, almost_full=1 from count 6 (AF_THRESH=6). Extra enq of FF -> overflow=1, count stays 8. Drain -> 01..08 (FF absent). clr_err -> overflow=0.
3. Full, then enq=deq=1 with din=A5 for one cycle -> count stays 8, pop returns 01, and A5 emerges last after 02..08.
4. Empty, deq alone -> underflow=1, count=0. Empty with enq=deq=1, din=3C -> count=1, underflow=1, then deq returns 3C.
5. 20 enq/deq pairs (values 00..13) streamed through an 8-deep FIFO -> in-order output across 2+ pointer wraps, count never above 2.
6. SHOW_AHEAD=1: enq 5A into empty -> dout=5A the next cycle with no deq. Then enq 6B and assert reset mid-stream with count=2 -> after reset empty=1, count=0, flags cleared, and subsequent enq 77 then deq returns 77.
